// File: rtl/btn_pkg.sv
// ============================================================================
// Module : btn_pkg
// Desc   : State encodings shared by the press generator and the detector benches.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sat_updown_counter.sv
// ============================================================================
// Module : sat_updown_counter
// Desc   : Unsigned up/down counter clamped to [0, MAX_PEND]; inc+dec together hold.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_updown_counter #(
  parameter int PW       = 3,
  parameter int MAX_PEND = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] cnt,
  output logic          sat
);

  localparam logic [PW-1:0] CNT_MAX = PW'(MAX_PEND);

  assign sat = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && !sat) begin
      cnt <= cnt + PW'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - PW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_press_generator.sv
// ============================================================================
// Module : button_press_generator
// Desc   : Drives y high for a hold time then low for a gap per request, replaying queued requests.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_press_generator
  import btn_pkg::*;
#(
  parameter  int CW       = 8,
  parameter  int MAX_PEND = 7,
  localparam int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [CW-1:0] hold_len,
  input  logic [CW-1:0] gap_len,
  output logic          y,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [PW-1:0] pend_cnt
);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] gap_lat, gap_lat_nxt;
  logic          y_nxt, busy_nxt, done_nxt, overflow_nxt;

  logic [CW-1:0] hold_m1, gap_m1;
  logic          cnt_zero, gap_end, pend_nz, pend_sat, pend_inc, pend_dec;

  // Zero lengths behave as one cycle, so the counter load saturates at 0.
  assign hold_m1  = (hold_len == '0) ? '0 : hold_len - CW'(1);
  assign gap_m1   = (gap_len == '0)  ? '0 : gap_len - CW'(1);
  assign cnt_zero = (cnt == '0);
  assign gap_end  = (state == ST_GAP) && cnt_zero;
  assign pend_nz  = (pend_cnt != '0);
  assign pend_dec = gap_end && pend_nz;
  // A req on the last gap cycle with an empty queue starts the next press directly.
  assign pend_inc = req && (state != ST_IDLE) && !(gap_end && !pend_nz);

  sat_updown_counter #(
    .PW       (PW),
    .MAX_PEND (MAX_PEND)
  ) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pend_inc),
    .dec   (pend_dec),
    .cnt   (pend_cnt),
    .sat   (pend_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      gap_lat  <= '0;
      y        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gap_lat  <= gap_lat_nxt;
      y        <= y_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      overflow <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gap_lat_nxt = gap_lat;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_nxt   = ST_PRESS;
          cnt_nxt     = hold_m1;
          gap_lat_nxt = gap_m1;
        end
      end
      ST_PRESS: begin
        if (cnt_zero) begin
          state_nxt = ST_GAP;
          cnt_nxt   = gap_lat;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          if (pend_nz || req) begin
            state_nxt   = ST_PRESS;
            cnt_nxt     = hold_m1;
            gap_lat_nxt = gap_m1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    y_nxt        = (state_nxt == ST_PRESS);
    busy_nxt     = (state_nxt != ST_IDLE);
    done_nxt     = (state == ST_PRESS) && (state_nxt == ST_GAP);
    overflow_nxt = pend_inc && !pend_dec && pend_sat;
  end

endmodule

`default_nettype wire

// File: tb/tb_button_press_generator.sv
// ============================================================================
// Module : tb_button_press_generator
// Desc   : Directed self-checking bench for button_press_generator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_press_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [7:0] hold_len, gap_len;
  logic       y, busy, done, overflow;
  logic [2:0] pend_cnt;

  int checks   = 0;
  int failures = 0;

  button_press_generator #(.CW(8), .MAX_PEND(7)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .hold_len (hold_len),
    .gap_len  (gap_len),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; hold_len = 8'd1; gap_len = 8'd1;
    #3;
    checks++; if ({y, busy, done, overflow, pend_cnt} !== 7'd0) begin failures++; $display("FAIL reset_async outs=%b required=0000000", {y, busy, done, overflow, pend_cnt}); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({y, busy, done, overflow, pend_cnt} !== 7'd0) begin failures++; $display("FAIL reset_release outs=%b required=0000000", {y, busy, done, overflow, pend_cnt}); end
  endtask

  task automatic test_single();
    logic ey, ed, eb;
    hold_len = 8'd3; gap_len = 8'd2; req = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      tick();
      req = 1'b0;
      ey = (k < 3); ed = (k == 3); eb = (k < 5);
      checks++; if ({y, done, busy} !== {ey, ed, eb}) begin failures++; $display("FAIL single k=%0d y/done/busy=%b required=%b", k, {y, done, busy}, {ey, ed, eb}); end
    end
  endtask

  task automatic test_zero_len();
    logic ey, ed, eb;
    hold_len = 8'd0; gap_len = 8'd0; req = 1'b1;
    for (int k = 0; k <= 2; k++) begin
      tick();
      req = 1'b0;
      ey = (k == 0); ed = (k == 1); eb = (k < 2);
      checks++; if ({y, done, busy} !== {ey, ed, eb}) begin failures++; $display("FAIL zero_len k=%0d y/done/busy=%b required=%b", k, {y, done, busy}, {ey, ed, eb}); end
    end
  endtask

  task automatic test_queueing();
    logic ey, ed, eb, py, e;
    logic [2:0] ep;
    int ndone = 0;
    int pmax = 0;
    hold_len = 8'd2; gap_len = 8'd2;
    for (int k = 0; k <= 12; k++) begin
      req = (k == 0) || (k == 1) || (k == 3);
      py = y;
      tick();
      req = 1'b0;
      e  = py && !y;
      ey = (k == 0) || (k == 1) || (k == 4) || (k == 5) || (k == 8) || (k == 9);
      ed = (k == 2) || (k == 6) || (k == 10);
      eb = (k < 12);
      ep = (k == 0) ? 3'd0 : (k <= 2) ? 3'd1 : (k == 3) ? 3'd2 : (k <= 7) ? 3'd1 : 3'd0;
      if (done) ndone++;
      if (int'(pend_cnt) > pmax) pmax = int'(pend_cnt);
      checks++; if ({y, done, busy, pend_cnt} !== {ey, ed, eb, ep}) begin failures++; $display("FAIL queue k=%0d y/done/busy/pend=%b required=%b", k, {y, done, busy, pend_cnt}, {ey, ed, eb, ep}); end
      checks++; if (done !== e) begin failures++; $display("FAIL loopback k=%0d done=%b required_e=%b", k, done, e); end
    end
    checks++; if (ndone != 3 || pmax != 2) begin failures++; $display("FAIL queue_totals dones=%0d peak=%0d required 3 and 2", ndone, pmax); end
  endtask

  task automatic test_overflow();
    int ndone = 0;
    int n = 0;
    hold_len = 8'd20; gap_len = 8'd1;
    for (int k = 0; k <= 9; k++) begin
      req = (k <= 8);
      tick();
      req = 1'b0;
      if (done) ndone++;
      checks++; if (overflow !== (k == 8)) begin failures++; $display("FAIL overflow_pulse k=%0d overflow=%b required=%b", k, overflow, (k == 8)); end
      if (k >= 7) begin
        checks++; if (pend_cnt !== 3'd7) begin failures++; $display("FAIL overflow_pend k=%0d pend=%0d required=7", k, pend_cnt); end
      end
    end
    while (busy && n < 400) begin
      tick();
      if (done) ndone++;
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_drain overflow=%b required=0", overflow); end
      n++;
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL overflow_timeout busy=%b required=0", busy); end
    checks++; if (ndone != 8) begin failures++; $display("FAIL overflow_presses dones=%0d required=8", ndone); end
  endtask

  task automatic test_back_to_back();
    hold_len = 8'd2; gap_len = 8'd2;
    for (int k = 0; k <= 12; k++) begin
      req = (k == 0) || (k == 1) || (k == 4);
      tick();
      req = 1'b0;
      if (k == 3) begin
        checks++; if ({y, pend_cnt} !== {1'b0, 3'd1}) begin failures++; $display("FAIL simul_pre y/pend=%b required=0001", {y, pend_cnt}); end
      end
      if (k == 4) begin
        checks++; if ({y, overflow, pend_cnt} !== {1'b1, 1'b0, 3'd1}) begin failures++; $display("FAIL simul_pop y/ovf/pend=%b required=10001", {y, overflow, pend_cnt}); end
      end
      if (k == 8) begin
        checks++; if ({y, pend_cnt} !== {1'b1, 3'd0}) begin failures++; $display("FAIL simul_last y/pend=%b required=1000", {y, pend_cnt}); end
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL simul_idle busy=%b required=0", busy); end
  endtask

  task automatic test_reset_mid_press();
    hold_len = 8'd5; gap_len = 8'd1; req = 1'b1;
    tick();
    tick();
    req = 1'b0;
    checks++; if ({y, pend_cnt} !== {1'b1, 3'd1}) begin failures++; $display("FAIL midrst_pre y/pend=%b required=1001", {y, pend_cnt}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({y, busy, done, overflow, pend_cnt} !== 7'd0) begin failures++; $display("FAIL midrst_async outs=%b required=0000000", {y, busy, done, overflow, pend_cnt}); end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({y, busy, done, pend_cnt} !== 6'd0) begin failures++; $display("FAIL midrst_after k=%0d outs=%b required=000000", k, {y, busy, done, pend_cnt}); end
    end
    hold_len = 8'd1; gap_len = 8'd1; req = 1'b1;
    tick();
    req = 1'b0;
    checks++; if ({y, busy, done} !== 3'b110) begin failures++; $display("FAIL midrst_new0 y/busy/done=%b required=110", {y, busy, done}); end
    tick();
    checks++; if ({y, busy, done} !== 3'b011) begin failures++; $display("FAIL midrst_new1 y/busy/done=%b required=011", {y, busy, done}); end
    tick();
    checks++; if ({y, busy, done} !== 3'b000) begin failures++; $display("FAIL midrst_new2 y/busy/done=%b required=000", {y, busy, done}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_len();
    test_queueing();
    test_overflow();
    test_back_to_back();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
